mult_t_c1x1_f0_16x16: RTL and testbench

//  16x16 mixed-signedness multiplier with a redundant two-word output: two 32-bit partial sums plus one carry bit.

---
 rtl/mult_pkg.sv | 17 +
 rtl/pp_mult_17x9.sv | 16 +
 rtl/mult_t_c1x1_f0_16x16.sv | 76 +++++++
 tb/tb_mult_t_c1x1_f0_16x16.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and result type for the 16x16 redundant-output multiplier
package mult_pkg;

  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int RES_W = 32;

  localparam logic [1:0] MODE_16X16     = 2'b00;
  localparam logic [1:0] MODE_SUM_16X16 = 2'b01;

  typedef struct packed {
    logic [RES_W-1:0] r0;
    logic [RES_W-1:0] r1;
    logic             carry;
  } mult_res_t;

endpackage

// File: rtl/pp_mult_17x9.sv
// rtl/pp_mult_17x9.sv - signed 17x9 partial-product multiplier, 26-bit signed result
module pp_mult_17x9 (
  input  logic signed [16:0] a_i,
  input  logic signed [8:0]  b_i,
  output logic signed [25:0] p_o
);

  logic signed [25:0] a_x;
  logic signed [25:0] b_x;

  // Widen both operands first so the product is formed at full width.
  assign a_x = 26'(a_i);
  assign b_x = 26'(b_i);
  assign p_o = a_x * b_x;

endmodule

// File: rtl/mult_t_c1x1_f0_16x16.sv
// rtl/mult_t_c1x1_f0_16x16.sv - 16x16 mixed-sign multiplier with redundant two-word output
module mult_t_c1x1_f0_16x16
  import mult_pkg::*;
#(
  parameter int REG_OUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [1:0]  mode,
  output logic [31:0] result_0,
  output logic [31:0] result_1,
  output logic        result_SIDM_carry
);

  logic signed [16:0] a_ext;
  logic signed [8:0]  b_lo;
  logic signed [8:0]  b_hi;
  logic signed [25:0] pp_l;
  logic signed [25:0] pp_h;
  logic [32:0]        pp_l_w;
  logic [32:0]        pp_h_w;
  logic [1:0]         mode_eff;
  logic               sum_mode;
  mult_res_t          res_d;
  mult_res_t          res_q;
  mult_res_t          res_o;

  assign a_ext = {a[15] & a_sign, a};
  assign b_lo  = {1'b0, b[7:0]};
  assign b_hi  = {b[15] & b_sign, b[15:8]};

  pp_mult_17x9 u_pp_lo (
    .a_i (a_ext),
    .b_i (b_lo),
    .p_o (pp_l)
  );

  pp_mult_17x9 u_pp_hi (
    .a_i (a_ext),
    .b_i (b_hi),
    .p_o (pp_h)
  );

  // Both partial products fit in 25 signed bits, so 33 bits holds them exactly.
  assign pp_l_w = 33'(pp_l);
  assign pp_h_w = 33'({pp_h, 8'b0});

  // Masking mode[1] keeps an undriven upper bit from reaching the carry.
  assign mode_eff = mode & 2'b01;
  assign sum_mode = (mode_eff == MODE_SUM_16X16);

  always_comb begin
    res_d       = '0;
    res_d.r0    = pp_l_w[31:0];
    res_d.r1    = pp_h_w[31:0];
    res_d.carry = sum_mode & (pp_l_w[32] ^ pp_h_w[32]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o             = (REG_OUT != 0) ? res_q : res_d;
  assign result_0          = res_o.r0;
  assign result_1          = res_o.r1;
  assign result_SIDM_carry = res_o.carry;

endmodule

// File: tb/tb_mult_t_c1x1_f0_16x16.sv
// tb/tb_mult_t_c1x1_f0_16x16.sv - self-checking bench for the redundant-output multiplier
module tb_mult_t_c1x1_f0_16x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic        a_sign;
  logic        b_sign;
  logic [1:0]  mode;

  logic [31:0] r0_c, r1_c, r0_r, r1_r;
  logic        c_c, c_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0;
  logic        reg_valid = 1'b0;
  logic [31:0] er0_q, er1_q;
  logic        ec_q;

  always #5 clk = ~clk;

  mult_t_c1x1_f0_16x16 #(.REG_OUT(0)) dut_comb (
    .clk               (clk),
    .reset             (reset),
    .a                 (a),
    .b                 (b),
    .a_sign            (a_sign),
    .b_sign            (b_sign),
    .mode              (mode),
    .result_0          (r0_c),
    .result_1          (r1_c),
    .result_SIDM_carry (c_c)
  );

  mult_t_c1x1_f0_16x16 #(.REG_OUT(1)) dut_reg (
    .clk               (clk),
    .reset             (reset),
    .a                 (a),
    .b                 (b),
    .a_sign            (a_sign),
    .b_sign            (b_sign),
    .mode              (mode),
    .result_0          (r0_r),
    .result_1          (r1_r),
    .result_SIDM_carry (c_r)
  );

  function automatic longint sval(input logic [15:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Expected outputs from plain integer arithmetic on the operand values.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mas,
                       input logic mbs, input logic [1:0] mm,
                       output logic [31:0] r0, output logic [31:0] r1, output logic c);
    longint av, hi, lo, pl, ph, prod, s;
    logic [7:0] hb;
    hb   = mb[15:8];
    av   = sval(ma, mas);
    lo   = longint'(mb[7:0]);
    hi   = mbs ? longint'($signed(hb)) : longint'(hb);
    pl   = av * lo;
    ph   = av * hi * 256;
    prod = av * sval(mb, mbs);
    r0   = pl[31:0];
    r1   = ph[31:0];
    s    = prod - longint'(r0) - longint'(r1);
    c    = mm[0] ? s[32] : 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      er0_q = '0;
      er1_q = '0;
      ec_q  = 1'b0;
    end else begin
      model(a, b, a_sign, b_sign, mode, er0_q, er1_q, ec_q);
    end
    reg_valid = 1'b1;
  end

  always @(negedge clk) begin
    logic [31:0] e0, e1;
    logic        ec;
    if (chk_en) begin
      model(a, b, a_sign, b_sign, mode, e0, e1, ec);
      check("comb_r0", r0_c, e0);
      check("comb_r1", r1_c, e1);
      check("comb_carry", c_c, ec);
      if (reg_valid) begin
        check("reg_r0", r0_r, er0_q);
        check("reg_r1", r1_r, er1_q);
        check("reg_carry", c_r, ec_q);
      end
    end
  end

  task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic tas,
                       input logic tbs, input logic [1:0] tm);
    @(posedge clk);
    #1;
    a      = ta;
    b      = tb;
    a_sign = tas;
    b_sign = tbs;
    mode   = tm;
    @(negedge clk);
  endtask

  function automatic logic [31:0] sum32(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

  function automatic logic [32:0] sum33(input logic c, input logic [31:0] x, input logic [31:0] y);
    return {c, x} + {1'b0, y};
  endfunction

  initial begin
    reset  = 1'b1;
    a      = '0;
    b      = '0;
    a_sign = 1'b0;
    b_sign = 1'b0;
    mode   = 2'b00;
    chk_en = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    a = 16'd7;
    b = 16'd9;
    @(negedge clk);
    @(negedge clk);
    check("rst_r0", r0_r, 32'h0);
    check("rst_r1", r1_r, 32'h0);
    check("rst_carry", c_r, 1'b0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    a     = 16'd3;
    b     = 16'd5;
    @(negedge clk);
    check("reg_hold_before_edge", sum32(r0_r, r1_r), 32'd0);
    @(negedge clk);
    check("reg_3x5_sum", sum32(r0_r, r1_r), 32'd15);
    check("reg_3x5_carry", c_r, 1'b0);

    apply(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    check("t1_sum", sum32(r0_c, r1_c), 32'hFFFE0001);
    check("t1_carry", c_c, 1'b0);

    apply(16'hFFFF, 16'h8000, 1'b1, 1'b1, 2'b00);
    check("t2_sum", sum32(r0_c, r1_c), 32'h00008000);

    apply(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2'b01);
    check("t3_sum33", sum33(c_c, r0_c, r1_c), 33'h0FFFE0001);

    apply(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2'b11);
    check("t3_mode1_ignored", sum33(c_c, r0_c, r1_c), 33'h0FFFE0001);

    apply(16'h8000, 16'hFFFF, 1'b1, 1'b0, 2'b01);
    check("t4_sum33", sum33(c_c, r0_c, r1_c), 33'h180008000);

    apply(16'h8000, 16'h8000, 1'b1, 1'b1, 2'b00);
    check("min_sq_sum", sum32(r0_c, r1_c), 32'h40000000);

    apply(16'h8000, 16'h8000, 1'b1, 1'b1, 2'b01);
    check("min_sq_sum33", sum33(c_c, r0_c, r1_c), 33'h040000000);

    for (int s = 0; s < 4; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 100; i++) begin
          apply(16'($urandom), 16'($urandom), s[1], s[0],
                {1'($urandom_range(0, 1)), m[0]});
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
